// File: rtl/buzzer_arbiter.sv
// Shares one time-multiplexed buzzer drive among NUM_REQ latched alarm requests.
// Round-robin by default; define BUZZER_ARB_FIXED_PRIORITY_EN for lowest-index-wins selection.
module buzzer_arbiter #(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned ON_CYCLES  = 31,
  parameter int unsigned GAP_CYCLES = 4,
  parameter int unsigned CNT_W      = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic [NUM_REQ-1:0] req,
  input  logic               clear,
  output logic [NUM_REQ-1:0] buzz,
  output logic               busy,
  output logic [NUM_REQ-1:0] pending,
  output logic [NUM_REQ-1:0] overrun
);

  localparam int unsigned IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned ON_LOAD  = ON_CYCLES - 1;
  localparam int unsigned GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [1:0] {S_IDLE, S_ON, S_GAP} state_t;

  state_t             r_state, w_state_nx;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nx;
  logic [NUM_REQ-1:0] r_buzz, w_buzz_nx;
  logic [NUM_REQ-1:0] r_pend, w_pend_nx;
  logic [NUM_REQ-1:0] r_ovr, w_ovr_nx;
  logic               r_busy;
  logic [NUM_REQ-1:0] w_take;
  logic               w_found;
  logic [IDX_W-1:0]   w_sel;

`ifdef BUZZER_ARB_FIXED_PRIORITY_EN
  // Lowest set pending index wins (descending scan, last hit kept).
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (r_pend[IDX_W'(i)]) begin
        w_found = 1'b1;
        w_sel   = IDX_W'(i);
      end
    end
  end
`else
  logic [IDX_W-1:0] r_last, w_last_nx;

  // First set bit after r_last, wrapping; descending offset scan keeps the nearest.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int unsigned off = NUM_REQ; off >= 1; off--) begin
      int unsigned idx;
      idx = (32'(r_last) + off) % NUM_REQ;
      if (r_pend[IDX_W'(idx)]) begin
        w_found = 1'b1;
        w_sel   = IDX_W'(idx);
      end
    end
  end
`endif

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_buzz_nx  = r_buzz;
    w_take     = '0;
`ifndef BUZZER_ARB_FIXED_PRIORITY_EN
    w_last_nx  = r_last;
`endif
    case (r_state)
      S_IDLE: begin
        w_buzz_nx = '0;
        if (w_found) begin
          w_take     = NUM_REQ'(1) << w_sel;
          w_buzz_nx  = NUM_REQ'(1) << w_sel;
          w_cnt_nx   = CNT_W'(ON_LOAD);
          w_state_nx = S_ON;
`ifndef BUZZER_ARB_FIXED_PRIORITY_EN
          w_last_nx  = w_sel;
`endif
        end
      end
      S_ON: begin
        if (r_cnt != '0) begin
          w_cnt_nx = r_cnt - CNT_W'(1);
        end else begin
          w_buzz_nx = '0;
          if (GAP_CYCLES > 0) begin
            w_cnt_nx   = CNT_W'(GAP_LOAD);
            w_state_nx = S_GAP;
          end else begin
            w_cnt_nx   = '0;
            w_state_nx = S_IDLE;
          end
        end
      end
      S_GAP: begin
        w_buzz_nx = '0;
        if (r_cnt != '0) w_cnt_nx = r_cnt - CNT_W'(1);
        else             w_state_nx = S_IDLE;
      end
      default: begin
        w_buzz_nx  = '0;
        w_cnt_nx   = '0;
        w_state_nx = S_IDLE;
      end
    endcase

    // A re-request on the grant edge re-queues without flagging overrun.
    w_pend_nx = (r_pend & ~w_take) | req;
    w_ovr_nx  = r_ovr | (req & r_pend & ~w_take);

    if (clear) begin
      w_state_nx = S_IDLE;
      w_cnt_nx   = '0;
      w_buzz_nx  = '0;
      w_pend_nx  = '0;
      w_ovr_nx   = '0;
`ifndef BUZZER_ARB_FIXED_PRIORITY_EN
      w_last_nx  = r_last;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_buzz  <= '0;
      r_pend  <= '0;
      r_ovr   <= '0;
      r_busy  <= 1'b0;
`ifndef BUZZER_ARB_FIXED_PRIORITY_EN
      r_last  <= IDX_W'(NUM_REQ - 1);
`endif
    end else if (ena) begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_buzz  <= w_buzz_nx;
      r_pend  <= w_pend_nx;
      r_ovr   <= w_ovr_nx;
      r_busy  <= (w_state_nx != S_IDLE);
`ifndef BUZZER_ARB_FIXED_PRIORITY_EN
      r_last  <= w_last_nx;
`endif
    end
  end

  assign buzz    = r_buzz;
  assign busy    = r_busy;
  assign pending = r_pend;
  assign overrun = r_ovr;

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Scoreboard bench for buzzer_arbiter: a grant-timeline model predicts outputs per edge,
// a negedge monitor pops and compares.
module tb_buzzer_arbiter;

  localparam int N   = 3;
  localparam int ON  = 31;
  localparam int GAP = 4;

  logic         clk = 1'b0;
  logic         rst, ena, clear;
  logic [N-1:0] req;
  logic [N-1:0] buzz, pending, overrun;
  logic         busy;

  always #5 clk = ~clk;

  buzzer_arbiter #(
    .NUM_REQ(N), .ON_CYCLES(ON), .GAP_CYCLES(GAP), .CNT_W(5)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena), .req(req), .clear(clear),
    .buzz(buzz), .busy(busy), .pending(pending), .overrun(overrun)
  );

  typedef struct packed {
    logic [N-1:0] buzz;
    logic         busy;
    logic [N-1:0] pend;
    logic [N-1:0] ovr;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Model: a grant occupies ON+GAP busy cycles; m_left counts what remains of it.
  logic [N-1:0] m_pend, m_ovr;
  int           m_left, m_cur, m_last;

  function automatic int pick(input logic [N-1:0] p, input int last);
`ifdef BUZZER_ARB_FIXED_PRIORITY_EN
    for (int i = 0; i < N; i++) if (p[i]) return i;
`else
    for (int k = 1; k <= N; k++) if (p[(last + k) % N]) return (last + k) % N;
`endif
    return -1;
  endfunction

  always @(posedge clk) begin : model
    exp_t         e;
    logic [N-1:0] gm;
    int           w;
    if (rst) begin
      m_pend = '0; m_ovr = '0; m_left = 0; m_cur = 0; m_last = N - 1;
    end else if (ena) begin
      if (clear) begin
        m_pend = '0; m_ovr = '0; m_left = 0;
      end else begin
        gm = '0;
        if (m_left == 0) begin
          w = pick(m_pend, m_last);
          if (w >= 0) begin
            gm = N'(1) << w;
            m_cur = w; m_last = w; m_left = ON + GAP;
          end
        end else begin
          m_left = m_left - 1;
        end
        m_ovr  = m_ovr | (req & m_pend & ~gm);
        m_pend = (m_pend & ~gm) | req;
      end
    end
    e.buzz = (m_left > GAP) ? N'(1) << m_cur : '0;
    e.busy = (m_left > 0);
    e.pend = m_pend;
    e.ovr  = m_ovr;
    q.push_back(e);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("buzz",    int'(buzz),    int'(e.buzz));
      chk("busy",    int'(busy),    int'(e.busy));
      chk("pending", int'(pending), int'(e.pend));
      chk("overrun", int'(overrun), int'(e.ovr));
    end
  end

  task automatic step(input logic [N-1:0] r, input logic c = 1'b0,
                      input logic e = 1'b1, input logic rs = 1'b0);
    req = r; clear = c; ena = e; rst = rs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; clear = 1'b0; req = '0;
    step('0, 1'b0, 1'b1, 1'b1);
    // first grant after reset
    step(3'b001);
    repeat (40) step('0);
    // round-robin, twice
    step(3'b111);
    repeat (120) step('0);
    step(3'b111);
    repeat (120) step('0);
    // overrun on ch1 while ch0 buzzes
    step(3'b001);
    repeat (5) step('0);
    step(3'b010); step('0); step(3'b010);
    repeat (100) step('0);
    // level-held ch0 re-queues behind ch1/ch2
    step(3'b111);
    repeat (150) step(3'b001);
    repeat (80) step('0);
    // clear mid-ON with pending set
    step(3'b100);
    repeat (8) step('0);
    step(3'b011);
    step('0, 1'b1);
    step('0);
    step(3'b001);
    repeat (50) step('0);
    // ena freeze mid-ON with req toggling
    step(3'b010);
    repeat (10) step('0);
    for (int i = 0; i < 8; i++) step(N'($urandom), 1'b0, 1'b0);
    repeat (50) step('0);
    // priority ordering case
    step(3'b110); step(3'b110); step(3'b001);
    repeat (200) step('0);
    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 11) == 0) ? N'($urandom) : '0,
           $urandom_range(0, 299) == 0,
           $urandom_range(0, 9) != 0,
           $urandom_range(0, 1499) == 0);
    end
    repeat (3) step('0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/buzzer_arbiter.md
Name: buzzer_arbiter

Overview:
- Shares one time-multiplexed buzzer drive among NUM_REQ alarm requesters. Requesters are the debounced sensor-detection channels.
- Each request is latched as pending. Pending requests are served round-robin.
- Each grant drives that channel's buzzer for exactly ON_CYCLES cycles, followed by a silent gap of GAP_CYCLES cycles.
- Sits between the sensor debounce logic and the uo buzzer pins.

Parameters:
- NUM_REQ, 3, number of requester/buzzer channels (2..8)
- ON_CYCLES, 31, buzzer-on duration per grant in clk cycles (>=1)
- GAP_CYCLES, 4, silent cycles after each grant (0 = no gap state)
- CNT_W, 5, duration counter width; must hold max(ON_CYCLES, GAP_CYCLES)

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous reset, active-high
- ena  input  1  clock enable; low freezes all state
- req  input  NUM_REQ  per-channel alarm request, sampled each enabled edge, level or pulse
- clear  input  1  synchronous abort: flush pending, stop buzzer, clear overrun
- buzz  output  NUM_REQ  one-hot buzzer drive (registered)
- busy  output  1  high in ON or GAP
- pending  output  NUM_REQ  latched, not-yet-served requests
- overrun  output  NUM_REQ  sticky: request arrived while same channel already pending

Behaviour:
- Reset (rst=1 at edge, regardless of ena):
  - state=IDLE; buzz=0; busy=0; pending=0; overrun=0; counter=0.
  - RR pointer last=NUM_REQ-1, so channel 0 has first priority.
- ena=0: all registers hold; req and clear ignored; outputs hold their values.
- Priority at an enabled edge: rst > clear > normal operation.
- clear=1:
  - pending=0, overrun=0, buzz=0, counter=0, state=IDLE.
  - RR pointer unchanged.
  - req in the same cycle is dropped.
- Pending latch, per channel i:
  - req[i]=1 sets pending[i].
  - If pending[i] is already 1 and is not being granted this edge, overrun[i] is also set.
  - If pending[i] is granted on the same edge that req[i]=1, the set wins: pending[i] stays 1, no overrun.
  - A level-held req therefore re-queues continuously.
- FSM: IDLE, ON, GAP.
  - IDLE, pending!=0:
    - Select the first set bit scanning from last+1 upward, wrapping modulo NUM_REQ.
    - Clear that pending bit; last=selected; buzz=onehot(selected); counter=ON_CYCLES-1; go ON.
  - IDLE, pending=0: stay; buzz=0.
  - ON:
    - buzz held.
    - counter!=0: decrement.
    - counter==0: buzz=0. If GAP_CYCLES>0, go GAP with counter=GAP_CYCLES-1; otherwise go IDLE.
  - GAP:
    - buzz=0.
    - counter!=0: decrement.
    - counter==0: go IDLE.
- Timing:
  - buzz is high for exactly ON_CYCLES consecutive enabled cycles per grant.
  - Consecutive grants are separated by exactly GAP_CYCLES+1 buzz-low cycles, including the IDLE select cycle.
- Latency: req[i] sampled at edge k while IDLE with pending=0 -> pending[i] high after edge k -> buzz[i] high after edge k+1.
- busy = (state != IDLE), registered with the state.
- At most one buzz bit is high at any time; no combinational path from req to buzz.
- A new req during ON/GAP never pre-empts the current grant.

Optional Feature:
- Macro BUZZER_ARB_FIXED_PRIORITY_EN.
- Defined: selection is fixed priority, lowest set pending index wins; the RR pointer is not implemented.
- Undefined (default): round-robin as above.
- All timing, clear and overrun behaviour is identical in both builds.

Test Plan:
- Reset/first grant: rst 1 cycle, then req=3'b001 for 1 cycle.
  - Required: pending=001 after that edge; buzz=001 from the next edge for 31 cycles; then 0; busy low after 4 GAP cycles.
- Round-robin: req=3'b111 for 1 cycle.
  - Required: grants in order ch0, ch1, ch2; each 31 cycles buzz high; 5 low cycles between grants.
  - Repeat req=3'b111: order is ch0, ch1, ch2 again, since last=2.
- Overrun/same-edge: req[1] pulsed twice while ch0 is buzzing.
  - Required: overrun=010 and ch1 served once.
  - req[0] held high continuously: ch0 re-granted after ch1 and ch2, with no overrun at ch0's grant edge.
- Clear mid-ON: clear=1 at ON cycle 10 of ch2 with pending=011.
  - Required: next cycle buzz=0, pending=0, overrun=0, busy=0.
  - A later req=001 is served immediately.
- ena freeze: ena=0 for 8 cycles mid-ON with req toggling.
  - Required: buzz, counter and pending frozen, req ignored; buzz total high count still 31 enabled cycles.
- BUZZER_ARB_FIXED_PRIORITY_EN build: req=3'b110 held 2 cycles, then req=3'b001.
  - Required: ch1 granted first, then ch0, then ch1 again (re-requested during the hold), then ch2.
